gmii_tx_framer: RTL and testbench

//  Parametrised GMII transmit framer, successor to the fixed-length handle_tx path.

---
 rtl/eth_pkg.sv | 39 +++
 rtl/eth_crc32_d8.sv | 28 ++
 rtl/gmii_tx_framer.sv | 234 +++++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared Ethernet definitions for the GMII transmit framer and the CRC block.
//   TypeByte     : one GMII octet
//   TypeTxState  : framer state encoding
//   ETH_PREAMBLE, ETH_SFD, CRC32_INIT : framing constants
//   crc32_d8()   : one-byte step of the IEEE 802.3 reflected CRC-32
// ---------------------------------------------------------------------------
package eth_pkg;

  typedef logic [7:0] TypeByte;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DROP,
    ST_IFG
  } TypeTxState;

  localparam TypeByte     ETH_PREAMBLE = 8'h55;
  localparam TypeByte     ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;

  // Reflected polynomial, data bit 0 enters first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input TypeByte d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// ---------------------------------------------------------------------------
// eth_crc32_d8
// Registered byte-wide CRC-32 accumulator (also intended for the RX checker).
//   clock   : clock
//   reset_n : async active-low reset, loads CRC32_INIT
//   init    : load CRC32_INIT on the next edge (wins over en)
//   en      : fold data into the running CRC on the next edge
//   data    : byte to fold in
//   crc     : running (non-inverted) CRC register
// ---------------------------------------------------------------------------
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  TypeByte     data,
  output logic [31:0] crc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc32_d8(crc, data);
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer
// Turns a payload byte stream into complete GMII frames: preamble, SFD,
// payload, optional zero pad, FCS, then an inter-frame gap. Underrun and
// oversize frames are aborted with tx_er and counted.
//
// Build option: define GMII_TX_PAD_EN to pad short payloads to MIN_PAYLOAD
// bytes of 0x00 (covered by the FCS). Without it runt frames go out as given.
//
// Ports
//   clock, reset_n         : 125 MHz GMII clock, async active-low reset
//   s_data/s_valid/s_last  : payload byte, its valid, end-of-payload marker
//   s_ready                : framer takes s_data this cycle
//   tx_data/tx_en/tx_er    : registered GMII TXD / TX_EN / TX_ER
//   busy                   : framer is not idle
//   frame_cnt, err_cnt     : good frames sent / frames aborted (wrapping)
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready.
// s_ready depends only on state (high in DATA and DROP), never on s_valid.
// s_valid must be raised to start a frame and held through preamble/SFD;
// s_last is meaningful only together with s_valid.
// ---------------------------------------------------------------------------
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  output logic             tx_er,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_pre
    $error("PREAMBLE_LEN must be 1..15");
  end
  if (IFG_BYTES < 1 || IFG_BYTES > 63) begin : g_bad_ifg
    $error("IFG_BYTES must be 1..63");
  end
  if (MIN_PAYLOAD < 1 || MIN_PAYLOAD > MAX_PAYLOAD || MAX_PAYLOAD > 2047) begin : g_bad_len
    $error("need 1 <= MIN_PAYLOAD <= MAX_PAYLOAD <= 2047");
  end

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  // The IDLE cycle that follows IFG is itself a gap cycle on the wire, so
  // IFG lasts one cycle less; with a 1-byte gap IFG is skipped entirely.
  localparam logic [10:0] IFG_LAST = 11'((IFG_BYTES > 1) ? IFG_BYTES - 2 : 0);
  localparam TypeTxState  GAP_ST   = (IFG_BYTES > 1) ? ST_IFG : ST_IDLE;
`ifdef GMII_TX_PAD_EN
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
`endif

  TypeTxState  state, state_nxt;
  logic [10:0] cnt, cnt_nxt;        // preamble / payload / FCS / gap index
  logic [10:0] cnt_inc;
  TypeByte     d_nxt;
  logic        en_nxt, er_nxt;
  logic        crc_init, crc_en;
  TypeByte     crc_din;
  logic [31:0] crc;
  logic [31:0] fcs_word;
  logic        inc_frame, inc_err;

  assign cnt_inc  = cnt + 11'd1;
  assign fcs_word = ~crc;
  assign busy     = (state != ST_IDLE);

  eth_crc32_d8 u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_en),
    .data    (crc_din),
    .crc     (crc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_data   <= '0;
      tx_en     <= 1'b0;
      tx_er     <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tx_data <= d_nxt;
      tx_en   <= en_nxt;
      tx_er   <= er_nxt;
      if (inc_frame) frame_cnt <= frame_cnt + CNT_W'(1);
      if (inc_err)   err_cnt   <= err_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = 8'h00;
    en_nxt    = 1'b0;
    er_nxt    = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    crc_din   = s_data;
    s_ready   = 1'b0;
    inc_frame = 1'b0;
    inc_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (s_valid) state_nxt = ST_PRE;
      end
      ST_PRE: begin
        d_nxt  = ETH_PREAMBLE;
        en_nxt = 1'b1;
        if (cnt == PRE_LAST) begin
          state_nxt = ST_SFD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_SFD: begin
        d_nxt     = ETH_SFD;
        en_nxt    = 1'b1;
        cnt_nxt   = '0;
        crc_init  = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_ready = 1'b1;
        en_nxt  = 1'b1;
        if (s_valid) begin
          d_nxt   = s_data;
          crc_en  = 1'b1;
          cnt_nxt = cnt_inc;
          if (s_last) begin
`ifdef GMII_TX_PAD_EN
            if (cnt_inc < MIN_CNT) begin
              state_nxt = ST_PAD;
            end else begin
              state_nxt = ST_FCS;
              cnt_nxt   = '0;
            end
`else
            state_nxt = ST_FCS;
            cnt_nxt   = '0;
`endif
          end else if (cnt_inc == MAX_CNT) begin
            // cnt stays non-zero on entry: DROP uses that to spot its first cycle.
            state_nxt = ST_DROP;
            inc_err   = 1'b1;
          end
        end else begin
          // Underrun: one poisoned byte, then abandon the frame.
          er_nxt    = 1'b1;
          inc_err   = 1'b1;
          state_nxt = GAP_ST;
          cnt_nxt   = '0;
        end
      end
`ifdef GMII_TX_PAD_EN
      ST_PAD: begin
        en_nxt  = 1'b1;
        crc_en  = 1'b1;
        crc_din = 8'h00;
        if (cnt_inc == MIN_CNT) begin
          state_nxt = ST_FCS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
`endif
      ST_FCS: begin
        en_nxt = 1'b1;
        case (cnt[1:0])
          2'd0:    d_nxt = fcs_word[7:0];
          2'd1:    d_nxt = fcs_word[15:8];
          2'd2:    d_nxt = fcs_word[23:16];
          default: d_nxt = fcs_word[31:24];
        endcase
        if (cnt[1:0] == 2'd3) begin
          inc_frame = 1'b1;
          state_nxt = GAP_ST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (cnt != '0) begin
          // First DROP cycle: the oversize byte goes out marked bad.
          en_nxt  = 1'b1;
          er_nxt  = 1'b1;
          d_nxt   = s_valid ? s_data : 8'h00;
          cnt_nxt = '0;
        end
        if (s_valid && s_last) begin
          state_nxt = GAP_ST;
          cnt_nxt   = '0;
        end
      end
      ST_IFG: begin
        if (cnt == IFG_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
module tb_gmii_tx_framer;

  localparam int P    = 7;
  localparam int IFG  = 12;
  localparam int MINP = 60;
  localparam int MAXP = 1514;
  localparam int CW   = 16;
`ifdef GMII_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset_n;
  logic [7:0]    s_data;
  logic          s_valid, s_last, s_ready;
  logic [7:0]    tx_data;
  logic          tx_en, tx_er, busy;
  logic [CW-1:0] frame_cnt, err_cnt;

  always #4 clock = ~clock;

  gmii_tx_framer #(
    .PREAMBLE_LEN (P),
    .IFG_BYTES    (IFG),
    .MIN_PAYLOAD  (MINP),
    .MAX_PAYLOAD  (MAXP),
    .CNT_W        (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .tx_er     (tx_er),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  // ---------------- model state ----------------
  typedef struct packed {
    logic          er;
    logic [7:0]    data;
    logic          last;
    logic          gap_chk;
    logic          gap_exact;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] ecnt;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  int          m_frames = 0, m_errs = 0;
  bit          have_prev = 1'b0, prev_drop = 1'b0;
  logic [7:0]  pl [0:1599];
  logic [31:0] crc_tbl [0:255];
  int          idle_run = 0, en_run = 0, last_len = 0;
  bit          open_f = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Byte-table CRC over a whole message; result is the transmitted FCS word.
  function automatic logic [31:0] fcs_of(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic push_e(input logic er, input logic [7:0] d, input logic last,
                        input logic gc, input logic ge);
    exp_t e;
    e.er = er; e.data = d; e.last = last; e.gap_chk = gc; e.gap_exact = ge;
    e.fcnt = CW'(m_frames); e.ecnt = CW'(m_errs);
    exp_q.push_back(e);
  endtask

  // Expected wire image of one frame built from the payload in pl[].
  task automatic model_frame(input int len, input int under_at, input bit b2b);
    bit gc, ge;
    bq_t q;
    logic [31:0] f;
    gc = have_prev;
    ge = b2b && !prev_drop;
    for (int i = 0; i < P; i++) begin
      push_e(1'b0, 8'h55, 1'b0, gc, ge);
      gc = 1'b0; ge = 1'b0;
    end
    push_e(1'b0, 8'hD5, 1'b0, 1'b0, 1'b0);
    if (under_at >= 0 && under_at < len) begin
      for (int i = 0; i < under_at; i++) push_e(1'b0, pl[i], 1'b0, 1'b0, 1'b0);
      m_errs++;
      push_e(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      prev_drop = 1'b0;
    end else if (len > MAXP) begin
      for (int i = 0; i < MAXP; i++) push_e(1'b0, pl[i], 1'b0, 1'b0, 1'b0);
      m_errs++;
      push_e(1'b1, pl[MAXP], 1'b1, 1'b0, 1'b0);
      prev_drop = 1'b1;
    end else begin
      for (int i = 0; i < len; i++) q.push_back(pl[i]);
      if (PAD_ON) while (q.size() < MINP) q.push_back(8'h00);
      foreach (q[i]) push_e(1'b0, q[i], 1'b0, 1'b0, 1'b0);
      f = fcs_of(q);
      m_frames++;
      push_e(1'b0, f[7:0],   1'b0, 1'b0, 1'b0);
      push_e(1'b0, f[15:8],  1'b0, 1'b0, 1'b0);
      push_e(1'b0, f[23:16], 1'b0, 1'b0, 1'b0);
      push_e(1'b0, f[31:24], 1'b1, 1'b0, 1'b0);
      prev_drop = 1'b0;
    end
    have_prev = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int len, input int under_at, input bit b2b);
    int  i, stall;
    bit  acc;
    model_frame(len, under_at, b2b);
    i = 0; stall = 0;
    while (i < len) begin
      @(negedge clock);
      if (i == under_at && s_ready) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clock);
        break;
      end
      s_valid = 1'b1;
      s_data  = pl[i];
      s_last  = (i == len - 1);
      acc     = s_ready;
      @(posedge clock);
      if (acc) begin
        i++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 200) begin
          n_cmp++; n_fail++;
          $display("FAIL drv_timeout: byte %0d of %0d not accepted", i, len);
          break;
        end
      end
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 6000) begin
      @(negedge clock);
      t++;
    end
    n_cmp++;
    if (t >= 6000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, busy %0b", exp_q.size(), busy);
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    exp_t e;
    if (chk_en && reset_n) begin
      if (tx_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_tx: got tx_data %0h with nothing expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (!open_f && e.gap_chk) begin
            if (e.gap_exact) chk("ifg_exact", 64'(idle_run), 64'(IFG));
            else begin
              n_cmp++;
              if (idle_run < IFG) begin
                n_fail++;
                $display("FAIL ifg_min: got %0d idle cycles expected >= %0d", idle_run, IFG);
              end
            end
          end
          chk("tx_er", 64'(tx_er), 64'(e.er));
          chk("tx_data", 64'(tx_data), 64'(e.data));
          open_f = !e.last;
          en_run++;
          if (e.last) begin
            chk("frame_cnt", 64'(frame_cnt), 64'(e.fcnt));
            chk("err_cnt", 64'(err_cnt), 64'(e.ecnt));
            last_len = en_run;
            en_run   = 0;
          end
        end
        idle_run = 0;
      end else begin
        if (open_f) begin
          n_cmp++; n_fail++;
          $display("FAIL gap_in_frame: got tx_en 0 expected 1 (t=%0t)", $time);
        end
        chk("idle_tx_er", 64'(tx_er), 64'd0);
        chk("idle_tx_data", 64'(tx_data), 64'd0);
        idle_run++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bq_t ref_q;
    int  len, und, got, t;
    bit  b2b, acc;
    logic [31:0] v;

    for (int n = 0; n < 256; n++) begin
      v = 32'(n);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
      crc_tbl[n] = v;
    end

    reset_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_en", 64'(tx_en), 64'd0);
    chk("rst_tx_er", 64'(tx_er), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Pin the model's CRC against the standard check value.
    for (int i = 0; i < 9; i++) ref_q.push_back(8'h31 + 8'(i));
    chk("model_crc_check", 64'(fcs_of(ref_q)), 64'h0000_0000_CBF4_3926);

    // "123456789"
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    go_idle(2);
    send_frame(9, -1, 1'b0);
    go_idle(0);
    wait_drain();
    chk("t1_wire_len", 64'(last_len), PAD_ON ? 64'd72 : 64'd21);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // Underrun at byte 20 of a 100-byte frame.
    fill_random(100);
    go_idle(3);
    send_frame(100, 20, 1'b0);
    go_idle(0);
    wait_drain();
    chk("t3_err_cnt", 64'(err_cnt), 64'd1);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd1);

    // Underrun on the very first payload byte.
    fill_random(10);
    go_idle(1);
    send_frame(10, 0, 1'b0);

    // Random mix of lengths, underruns and back-to-back starts.
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(1, 120);
      und = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      b2b = 1'($urandom_range(0, 1));
      fill_random(len);
      if (!b2b) go_idle($urandom_range(0, 20));
      send_frame(len, und, b2b);
    end
    go_idle(0);
    wait_drain();

    // Two frames back to back: gap must be exactly IFG.
    fill_random(50);
    go_idle(2);
    send_frame(50, -1, 1'b0);
    fill_random(30);
    send_frame(30, -1, 1'b1);

    // Exactly MAX_PAYLOAD bytes is still a good frame.
    fill_random(MAXP);
    go_idle(1);
    send_frame(MAXP, -1, 1'b0);

    // Oversize by one, then by many, then a short frame straight after.
    fill_random(MAXP + 1);
    send_frame(MAXP + 1, -1, 1'b1);
    fill_random(1600);
    go_idle(4);
    send_frame(1600, -1, 1'b0);
    fill_random(5);
    send_frame(5, -1, 1'b1);
    go_idle(0);
    wait_drain();
    chk("t4_err_cnt", 64'(err_cnt), 64'(m_errs));

    // Reset in the middle of DATA.
    go_idle(2);
    chk_en = 1'b0;
    got = 0; t = 0;
    while (got < 5 && t < 100) begin
      @(negedge clock);
      s_valid = 1'b1;
      s_data  = 8'($urandom_range(0, 255));
      s_last  = 1'b0;
      acc     = s_ready;
      @(posedge clock);
      if (acc) got++;
      t++;
    end
    @(negedge clock);
    #1;
    chk("t6_pre_tx_en", 64'(tx_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_tx_en", 64'(tx_en), 64'd0);
    chk("t6_s_ready", 64'(s_ready), 64'd0);
    chk("t6_tx_data", 64'(tx_data), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("t6_err_cnt", 64'(err_cnt), 64'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_q.delete();
    m_frames = 0; m_errs = 0;
    have_prev = 1'b0; prev_drop = 1'b0;
    open_f = 1'b0; idle_run = 0; en_run = 0;
    @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    fill_random(12);
    go_idle(2);
    send_frame(12, -1, 1'b0);
    go_idle(0);
    wait_drain();
    chk("t6_clean_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_clean_err_cnt", 64'(err_cnt), 64'd0);

    chk("end_busy", 64'(busy), 64'd0);
    chk("end_s_ready", 64'(s_ready), 64'd0);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
